// File: rtl/display_source_arbiter.sv
// rtl/display_source_arbiter.sv - frame-tick generator and blank-inserting owner arbiter for the 8x24 LED matrix.
// Optional: define DISPLAY_FRAME_LATCH_EN to latch the owner's frame only on tick cycles.
module display_source_arbiter #(
    parameter int TICK_DIV     = 8000000,
    parameter int BLANK_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              req,
    input  logic [3:0][7:0][23:0]   src_frame,
    output logic                    tick,
    output logic [3:0]              grant,
    output logic                    switching,
    output logic [7:0][23:0]        out
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);
    localparam int BLK_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'(BLANK_FRAMES);
    localparam bit HAS_BLANK = (BLANK_FRAMES > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             holder_q, holder_d;
    logic [BLK_W-1:0]       blank_q, blank_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tick_q, tick_d;
    logic [3:0]             grant_q, grant_d;
    logic                   switching_q, switching_d;
    logic [7:0][23:0]       out_q, out_d;

    logic                   any_req;
    logic [1:0]             winner;
    logic                   higher_req;

    // Frame tick: registered, so it is high the cycle after the counter sat at its maximum.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_comb begin
        any_req = |req;
        casez (req)
            4'b1???: winner = 2'd3;
            4'b01??: winner = 2'd2;
            4'b001?: winner = 2'd1;
            default: winner = 2'd0;
        endcase
    end

    always_comb begin
        higher_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((i > int'(holder_q)) && req[i]) begin
                higher_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            holder_q    <= '0;
            blank_q     <= '0;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            grant_q     <= '0;
            switching_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            holder_q    <= holder_d;
            blank_q     <= blank_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            grant_q     <= grant_d;
            switching_q <= switching_d;
            out_q       <= out_d;
        end
    end

    // Ownership only moves on tick cycles; a losing or outranked owner triggers a blanked switch.
    always_comb begin
        state_d  = state_q;
        holder_d = holder_q;
        blank_d  = blank_q;
        if (tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        holder_d = winner;
                        if (HAS_BLANK) begin
                            state_d = ST_BLANK;
                            blank_d = BLK_INIT;
                        end else begin
                            state_d = ST_OWN;
                        end
                    end
                end
                ST_OWN: begin
                    if (!req[holder_q] || higher_req) begin
                        if (any_req) begin
                            holder_d = winner;
                            if (HAS_BLANK) begin
                                state_d = ST_BLANK;
                                blank_d = BLK_INIT;
                            end else begin
                                state_d = ST_OWN;
                            end
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_BLANK: begin
                    blank_d = blank_q - BLK_W'(1);
                    if (blank_q == BLK_W'(1)) begin
                        if (any_req) begin
                            holder_d = winner;
                            state_d  = ST_OWN;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they move on the same edge as ownership.
    always_comb begin
        grant_d     = '0;
        switching_d = (state_d == ST_BLANK);
        out_d       = '0;
        if (state_d == ST_OWN) begin
            grant_d = 4'b0001 << holder_d;
`ifdef DISPLAY_FRAME_LATCH_EN
            out_d   = tick_q ? src_frame[holder_d] : out_q;
`else
            out_d   = src_frame[holder_d];
`endif
        end
    end

    assign tick      = tick_q;
    assign grant     = grant_q;
    assign switching = switching_q;
    assign out       = out_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// tb/tb_display_source_arbiter.sv - self-checking bench for display_source_arbiter (two parameter sets).
module tb_display_source_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [3:0]             req;
    logic [3:0][7:0][23:0]  frames;

    logic                   tick_a, sw_a, tick_b, sw_b;
    logic [3:0]             grant_a, grant_b;
    logic [7:0][23:0]       out_a, out_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    display_source_arbiter #(.TICK_DIV(4), .BLANK_FRAMES(1)) dut_a (
        .clk(clk), .reset(reset), .req(req), .src_frame(frames),
        .tick(tick_a), .grant(grant_a), .switching(sw_a), .out(out_a)
    );

    display_source_arbiter #(.TICK_DIV(3), .BLANK_FRAMES(0)) dut_b (
        .clk(clk), .reset(reset), .req(req), .src_frame(frames),
        .tick(tick_b), .grant(grant_b), .switching(sw_b), .out(out_b)
    );

    // Reference model: mode 0 = idle, 1 = own, 2 = blank; ticks from cycle index arithmetic.
    int               m_k[2];
    int               m_mode[2];
    int               m_own[2];
    int               m_blank[2];
    logic             m_tick[2];
    logic             m_sw[2];
    logic [3:0]       m_grant[2];
    logic [7:0][23:0] m_out[2];

    function automatic int top_req(input logic [3:0] r);
        for (int j = 3; j >= 0; j--) begin
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input int i, input int td, input int bf);
        bit t;
        int w;
        if (reset) begin
            m_k[i] = 0; m_mode[i] = 0; m_own[i] = 0; m_blank[i] = 0;
            m_tick[i] = 1'b0; m_sw[i] = 1'b0; m_grant[i] = '0; m_out[i] = '0;
            return;
        end
        t = m_tick[i];
        w = top_req(req);
        m_tick[i] = (((m_k[i] + 1) % td) == 0);
        m_k[i]++;
        if (t) begin
            if (m_mode[i] == 0) begin
                if (w >= 0) begin
                    m_own[i] = w;
                    if (bf > 0) begin m_mode[i] = 2; m_blank[i] = bf; end
                    else m_mode[i] = 1;
                end
            end else if (m_mode[i] == 1) begin
                if (w != m_own[i]) begin
                    if (w < 0) m_mode[i] = 0;
                    else begin
                        m_own[i] = w;
                        if (bf > 0) begin m_mode[i] = 2; m_blank[i] = bf; end
                    end
                end
            end else begin
                m_blank[i]--;
                if (m_blank[i] == 0) begin
                    if (w >= 0) begin m_own[i] = w; m_mode[i] = 1; end
                    else m_mode[i] = 0;
                end
            end
        end
        m_sw[i]    = (m_mode[i] == 2);
        m_grant[i] = (m_mode[i] == 1) ? (4'b0001 << m_own[i]) : 4'b0000;
        if (m_mode[i] != 1) m_out[i] = '0;
`ifdef DISPLAY_FRAME_LATCH_EN
        else if (t) m_out[i] = frames[m_own[i]];
`else
        else m_out[i] = frames[m_own[i]];
`endif
    endtask

    always @(posedge clk) begin
        model_step(0, 4, 1);
        model_step(1, 3, 0);
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_tick_a",  tick_a,  m_tick[0]);
            chk("model_grant_a", grant_a, m_grant[0]);
            chk("model_sw_a",    sw_a,    m_sw[0]);
            chk("model_out_a",   out_a,   m_out[0]);
            chk("model_tick_b",  tick_b,  m_tick[1]);
            chk("model_grant_b", grant_b, m_grant[1]);
            chk("model_sw_b",    sw_b,    m_sw[1]);
            chk("model_out_b",   out_b,   m_out[1]);
        end
    end

    function automatic logic [191:0] fill(input logic [23:0] base, input bit add_row);
        logic [191:0] res;
        for (int r = 0; r < 8; r++) begin
            res[r*24 +: 24] = base | (add_row ? 24'(r) : 24'd0);
        end
        return res;
    endfunction

    task automatic cycles_to_tick(input int which, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((which == 0) ? tick_a : tick_b) !== 1'b1) && (n < 20));
    endtask

    task automatic after_tick(input string tag);
        int n;
        cycles_to_tick(0, n);
        n_checks++;
        if (n >= 20 && tick_a !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got no tick expected tick within 20 cycles", tag);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req   = 4'b0000;
        for (int r = 0; r < 8; r++) begin
            frames[0][r] = 24'hA5A5A5;
            frames[1][r] = 24'h110000 | 24'(r);
            frames[2][r] = 24'h220000 | 24'(r);
            frames[3][r] = 24'h330000 | 24'(r);
        end
        @(posedge clk);
        #1 started = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Tick cadence and idle outputs
        @(negedge clk);
        chk("t1_tick_low", tick_a, 1'b0);
        cycles_to_tick(0, n);
        chk("t1_first_tick", n, 4);
        cycles_to_tick(0, n);
        chk("t1_period", n, 4);
        chk("t1_grant", grant_a, 4'b0000);
        chk("t1_out", out_a, '0);

        // Request right after a tick: one blank frame, then ownership
        @(posedge clk);
        #2 req = 4'b0001;
        after_tick("t2_wait1");
        chk("t2_switching", sw_a, 1'b1);
        chk("t2_grant_blank", grant_a, 4'b0000);
        chk("t2_out_blank", out_a, '0);
        after_tick("t2_wait2");
        chk("t2_grant", grant_a, 4'b0001);
        chk("t2_switching_off", sw_a, 1'b0);
        chk("t2_out", out_a, fill(24'hA5A5A5, 1'b0));

        // Higher priority preempts via a blank frame
        req = 4'b1001;
        after_tick("t3_wait1");
        chk("t3_switching", sw_a, 1'b1);
        chk("t3_grant_blank", grant_a, 4'b0000);
        after_tick("t3_wait2");
        chk("t3_grant", grant_a, 4'b1000);
        chk("t3_out", out_a, fill(24'h330000, 1'b1));

        // All requests dropped
        req = 4'b0000;
        after_tick("t4_wait");
        chk("t4_grant", grant_a, 4'b0000);
        chk("t4_out", out_a, '0);
        chk("t4_switching", sw_a, 1'b0);

        // Re-arbitration at end of blank, no extra blank
        req = 4'b0100;
        after_tick("t5_wait1");
        chk("t5_switching", sw_a, 1'b1);
        req = 4'b0010;
        after_tick("t5_wait2");
        chk("t5_grant", grant_a, 4'b0010);
        chk("t5_switching_off", sw_a, 1'b0);
        chk("t5_out", out_a, fill(24'h110000, 1'b1));
        after_tick("t5_wait3");
        chk("t5_grant_hold", grant_a, 4'b0010);

        // Mid-period reset, counter restart, zero-blank direct ownership
        reset = 1'b1;
        @(negedge clk);
        chk("t6_tick_a", tick_a, 1'b0);
        chk("t6_grant_a", grant_a, 4'b0000);
        chk("t6_sw_a", sw_a, 1'b0);
        chk("t6_out_a", out_a, '0);
        chk("t6_grant_b", grant_b, 4'b0000);
        chk("t6_out_b", out_b, '0);
        reset = 1'b0;
        cycles_to_tick(1, n);
        chk("t6_b_restart", n, 3);
        @(negedge clk);
        chk("t6_b_grant", grant_b, 4'b0010);
        chk("t6_b_sw", sw_b, 1'b0);
        chk("t6_b_out", out_b, fill(24'h110000, 1'b1));
        chk("t6_a_restart", tick_a, 1'b1);
        @(negedge clk);
        chk("t6_a_blank", sw_a, 1'b1);

        // Short pulse that misses the tick is ignored
        after_tick("t7_wait1");
        chk("t7_grant", grant_a, 4'b0010);
        req = 4'b1010;
        @(negedge clk);
        req = 4'b0010;
        after_tick("t7_wait2");
        chk("t7_pulse_ignored", grant_a, 4'b0010);

        // Priority among several requests
        req = 4'b0111;
        after_tick("t8_wait1");
        chk("t8_switching", sw_a, 1'b1);
        after_tick("t8_wait2");
        chk("t8_grant", grant_a, 4'b0100);
        chk("t8_out", out_a, fill(24'h220000, 1'b1));

        repeat (6) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
